nerv_console_uart: RTL and testbench

// - Memory-mapped console sink on the NERV dmem bus; consumes CPU byte writes to the output address.
// - Buffers written bytes in a FIFO and serialises them as 8N1 UART on uart_tx.
// - Back-pressures the core through stall when the FIFO is full; exposes a status register.

---
 rtl/nerv_console_uart.sv | 168 ++++++++++++++++
 tb/tb_nerv_console_uart.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/nerv_console_uart.sv
// rtl/nerv_console_uart.sv - NERV dmem console sink: byte FIFO feeding an 8N1 UART transmitter
// TXDATA at BASE_ADDR, STATUS at BASE_ADDR+4; the core is stalled while the FIFO is full.

module nerv_console_uart #(
   parameter logic [31:0] BASE_ADDR  = 32'h02000000,
   parameter int          CLK_DIV    = 16,
   parameter int          FIFO_DEPTH = 16
) (
   input  logic        clock,
   input  logic        resetn,
   input  logic        dmem_valid,
   input  logic [31:0] dmem_addr,
   input  logic [3:0]  dmem_wstrb,
   input  logic [31:0] dmem_wdata,
   output logic [31:0] dmem_rdata,
   output logic        hit,
   output logic        stall,
   output logic        uart_tx
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int BW = $clog2(CLK_DIV);
   localparam logic [BW-1:0] BAUD_LOAD  = BW'(CLK_DIV - 1);
   localparam logic [AW:0]   LEVEL_FULL = (AW + 1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

   state_t        r_state;
   logic [7:0]    r_mem [FIFO_DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_level;
   logic [7:0]    r_shreg;
   logic [BW-1:0] r_baud;
   logic [2:0]    r_bit;
   logic          r_tx;
   logic [31:0]   r_rdata;

   state_t        w_state_nxt;
   logic [7:0]    w_shreg_nxt;
   logic [BW-1:0] w_baud_nxt;
   logic [2:0]    w_bit_nxt;
   logic          w_tx_nxt;
   logic          w_pop;
   logic          w_tx_sel;
   logic          w_full;
   logic          w_empty;
   logic          w_push;
   logic          w_baud_zero;
   logic [31:0]   w_status;
   logic          w_unused;

   assign w_tx_sel    = dmem_valid && (dmem_addr == BASE_ADDR);
   assign hit         = dmem_valid && (dmem_addr[31:3] == BASE_ADDR[31:3]);
   assign w_full      = (r_level == LEVEL_FULL);
   assign w_empty     = (r_level == '0);
   assign w_push      = w_tx_sel && dmem_wstrb[0] && !w_full;
   // Stall uses the registered level only, so a same-cycle pop never frees a slot early.
   assign stall       = w_tx_sel && (dmem_wstrb != 4'b0) && w_full;
   assign w_baud_zero = (r_baud == '0);
   assign w_status    = {16'b0, 8'(r_level), 5'b0, w_full, w_empty, r_state != S_IDLE};
   assign w_unused    = ^dmem_wdata[31:8];

   assign dmem_rdata  = r_rdata;
   assign uart_tx     = r_tx;

   always_comb begin
      w_state_nxt = r_state;
      w_shreg_nxt = r_shreg;
      w_baud_nxt  = r_baud;
      w_bit_nxt   = r_bit;
      w_tx_nxt    = r_tx;
      w_pop       = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_tx_nxt = 1'b1;
            if (!w_empty) begin
               w_pop       = 1'b1;
               w_shreg_nxt = r_mem[r_rd_ptr];
               w_tx_nxt    = 1'b0;
               w_baud_nxt  = BAUD_LOAD;
               w_state_nxt = S_START;
            end
         end
         S_START: begin
            if (w_baud_zero) begin
               w_tx_nxt    = r_shreg[0];
               w_shreg_nxt = {1'b0, r_shreg[7:1]};
               w_bit_nxt   = 3'd0;
               w_baud_nxt  = BAUD_LOAD;
               w_state_nxt = S_DATA;
            end else begin
               w_baud_nxt = r_baud - BW'(1);
            end
         end
         S_DATA: begin
            if (w_baud_zero) begin
               w_baud_nxt = BAUD_LOAD;
               if (r_bit == 3'd7) begin
                  w_tx_nxt    = 1'b1;
                  w_state_nxt = S_STOP;
               end else begin
                  w_tx_nxt    = r_shreg[0];
                  w_shreg_nxt = {1'b0, r_shreg[7:1]};
                  w_bit_nxt   = r_bit + 3'd1;
               end
            end else begin
               w_baud_nxt = r_baud - BW'(1);
            end
         end
         S_STOP: begin
            if (w_baud_zero) begin
               if (!w_empty) begin
                  w_pop       = 1'b1;
                  w_shreg_nxt = r_mem[r_rd_ptr];
                  w_tx_nxt    = 1'b0;
                  w_baud_nxt  = BAUD_LOAD;
                  w_state_nxt = S_START;
               end else begin
                  w_state_nxt = S_IDLE;
               end
            end else begin
               w_baud_nxt = r_baud - BW'(1);
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (w_push) r_mem[r_wr_ptr] <= dmem_wdata[7:0];
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_state  <= S_IDLE;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
         r_shreg  <= 8'h00;
         r_baud   <= '0;
         r_bit    <= 3'd0;
         r_tx     <= 1'b1;
      end else begin
         r_state <= w_state_nxt;
         r_shreg <= w_shreg_nxt;
         r_baud  <= w_baud_nxt;
         r_bit   <= w_bit_nxt;
         r_tx    <= w_tx_nxt;
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_level <= r_level + (AW + 1)'(1);
            2'b01:   r_level <= r_level - (AW + 1)'(1);
            default: r_level <= r_level;
         endcase
      end
   end

   // Only hit reads update rdata; word offset 4 is STATUS, offset 0 reads as zero.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_rdata <= 32'h0;
      end else if (hit && dmem_wstrb == 4'b0) begin
         r_rdata <= dmem_addr[2] ? w_status : 32'h0;
      end
   end

endmodule

// File: tb/tb_nerv_console_uart.sv
// tb/tb_nerv_console_uart.sv - scoreboard bench for nerv_console_uart
// Expected bytes/readbacks are queued at issue time; monitors decode uart_tx and dmem_rdata.

module tb_nerv_console_uart;
   localparam logic [31:0] BASE = 32'h02000000;

   typedef struct {
      logic [7:0] b;
      int         start;
   } exp_t;

   logic        clock = 1'b0;
   logic        resetn = 1'b0;
   logic        dmem_valid, v64;
   logic [31:0] dmem_addr, a64;
   logic [3:0]  dmem_wstrb, s64;
   logic [31:0] dmem_wdata, d64;
   logic [31:0] dmem_rdata, rdata64;
   logic        hit, stall, uart_tx, hit64, stall64, tx64;

   int          cyc = 0;
   int          checks = 0;
   int          failures = 0;
   exp_t        exp_q[$];
   logic [31:0] rd_q[$];
   logic        rd_pend = 1'b0;
   logic        mon_en = 1'b0;

   logic [9:0]  m_bits;
   int          m_start;
   logic        m_bad, m_abort;
   exp_t        m_e;

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   nerv_console_uart #(.BASE_ADDR(BASE), .CLK_DIV(4), .FIFO_DEPTH(16)) dut (
      .clock(clock), .resetn(resetn), .dmem_valid(dmem_valid), .dmem_addr(dmem_addr),
      .dmem_wstrb(dmem_wstrb), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
      .hit(hit), .stall(stall), .uart_tx(uart_tx));

   nerv_console_uart #(.BASE_ADDR(BASE), .CLK_DIV(64), .FIFO_DEPTH(16)) dut64 (
      .clock(clock), .resetn(resetn), .dmem_valid(v64), .dmem_addr(a64),
      .dmem_wstrb(s64), .dmem_wdata(d64), .dmem_rdata(rdata64),
      .hit(hit64), .stall(stall64), .uart_tx(tx64));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
      end
   endtask

   task automatic wr(input logic [31:0] a, input logic [3:0] s, input logic [7:0] d, output int acc);
      int n;
      @(negedge clock);
      dmem_valid = 1'b1; dmem_addr = a; dmem_wstrb = s; dmem_wdata = {24'hA5C3E1, d};
      n = 0;
      #1;
      while (stall === 1'b1 && n < 1000) begin
         @(negedge clock); #1; n++;
      end
      if (n >= 1000) chk("stall_timeout", 32'(n), 32'd0);
      acc = cyc + 1;
      @(posedge clock);
   endtask

   task automatic rd(input logic [31:0] a, input logic [31:0] exp);
      @(negedge clock);
      dmem_valid = 1'b1; dmem_addr = a; dmem_wstrb = 4'b0; dmem_wdata = 32'h0;
      rd_q.push_back(exp);
      @(posedge clock);
   endtask

   task automatic idle();
      @(negedge clock);
      dmem_valid = 1'b0; dmem_wstrb = 4'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 3000) begin
         @(negedge clock); n++;
      end
      chk("uart_drain", 32'(exp_q.size()), 32'd0);
   endtask

   always @(posedge clock)
      rd_pend <= dmem_valid && dmem_wstrb == 4'b0 && dmem_addr[31:3] == 29'(BASE >> 3);

   always @(negedge clock) begin
      if (rd_pend) begin
         if (rd_q.size() == 0) chk("rdata_unexpected", 32'd1, 32'd0);
         else chk("rdata", dmem_rdata, rd_q.pop_front());
      end
   end

   // UART receiver: a frame starts at the first low sample; every bit must hold for 4 cycles.
   initial begin
      forever begin
         @(negedge clock);
         if (resetn && uart_tx === 1'b0) begin
            m_start = cyc; m_bad = 1'b0; m_abort = 1'b0;
            for (int b = 0; b < 10; b++) begin
               for (int k = 0; k < 4; k++) begin
                  if (b != 0 || k != 0) @(negedge clock);
                  if (!resetn) m_abort = 1'b1;
                  if (k == 0) m_bits[b] = uart_tx;
                  else if (uart_tx !== m_bits[b]) m_bad = 1'b1;
               end
            end
            if (!m_abort && mon_en) begin
               if (exp_q.size() == 0) begin
                  chk("uart_unexpected_frame", {24'h0, m_bits[8:1]}, 32'hFFFFFFFF);
               end else begin
                  m_e = exp_q.pop_front();
                  chk("uart_byte", {24'h0, m_bits[8:1]}, {24'h0, m_e.b});
                  chk("uart_framing", {29'h0, m_bits[9], m_bits[0], m_bad}, 32'h4);
                  if (m_e.start >= 0) chk("uart_start_edge", 32'(m_start), 32'(m_e.start));
               end
            end
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int a, a0, a1;
      int acc[18];
      logic [7:0] rb[5];
      dmem_valid = 1'b0; dmem_addr = 32'h0; dmem_wstrb = 4'b0; dmem_wdata = 32'h0;
      v64 = 1'b0; a64 = 32'h0; s64 = 4'b0; d64 = 32'h0;
      repeat (3) @(negedge clock);
      chk("reset_uart_tx", {31'h0, uart_tx}, 32'd1);
      chk("reset_stall", {31'h0, stall}, 32'd0);
      chk("reset_rdata", dmem_rdata, 32'h0);
      chk("reset_hit", {31'h0, hit}, 32'd0);
      resetn = 1'b1;
      mon_en = 1'b1;
      rd(BASE + 4, 32'h00000002);
      idle();

      // Single byte 0x41: start bit from the edge after acceptance, then idle STATUS.
      wr(BASE, 4'b0001, 8'h41, a);
      exp_q.push_back('{b: 8'h41, start: a + 1});
      idle();
      drain();
      repeat (4) @(negedge clock);
      rd(BASE + 4, 32'h00000002);
      idle();

      // Back-to-back frames: second start bit exactly 40 cycles after the first.
      wr(BASE, 4'b0001, 8'h55, a0);
      exp_q.push_back('{b: 8'h55, start: a0 + 1});
      wr(BASE, 4'b0001, 8'hAA, a1);
      exp_q.push_back('{b: 8'hAA, start: a0 + 41});
      idle();
      chk("b2b_accept", 32'(a1), 32'(a0 + 1));
      drain();
      repeat (4) @(negedge clock);

      // Accesses that must not push.
      wr(BASE, 4'b0010, 8'h77, a);
      #1;
      chk("wstrb1_hit", {31'h0, hit}, 32'd1);
      chk("wstrb1_stall", {31'h0, stall}, 32'd0);
      wr(BASE + 8, 4'b0001, 8'h66, a);
      #1;
      chk("offrange_hit", {31'h0, hit}, 32'd0);
      wr(BASE + 4, 4'b0001, 8'h33, a);
      rd(BASE, 32'h0);
      rd(BASE + 4, 32'h00000002);
      idle();
      repeat (50) @(negedge clock);

      // 18 writes: 17 accepted back-to-back, the 18th after the first STOP->START pop.
      for (int i = 0; i < 18; i++) begin
         wr(BASE, 4'b0001, 8'(i * 13 + 5), acc[i]);
         exp_q.push_back('{b: 8'(i * 13 + 5), start: acc[0] + 1 + 40 * i});
      end
      idle();
      for (int i = 1; i < 17; i++) chk("fill_accept", 32'(acc[i]), 32'(acc[0] + i));
      chk("full_stall_accept", 32'(acc[17]), 32'(acc[0] + 42));
      drain();
      repeat (8) @(negedge clock);
      rd(BASE + 4, 32'h00000002);
      idle();

      // CLK_DIV=64: three writes then STATUS shows level 2, busy.
      @(negedge clock); v64 = 1'b1; a64 = BASE; s64 = 4'b0001; d64 = 32'h31;
      @(negedge clock); d64 = 32'h32;
      @(negedge clock); d64 = 32'h33;
      @(negedge clock); s64 = 4'b0000; a64 = BASE + 4;
      @(negedge clock); v64 = 1'b0;
      chk("status_clkdiv64", rdata64, 32'h00000201);

      // Reset during DATA bit 3 with 5 bytes queued: abort, flush, silence.
      mon_en = 1'b0;
      rb[0] = 8'hF0; rb[1] = 8'h11; rb[2] = 8'h22; rb[3] = 8'h33; rb[4] = 8'h44;
      wr(BASE, 4'b0001, rb[0], a0);
      for (int i = 1; i < 5; i++) wr(BASE, 4'b0001, rb[i], a);
      idle();
      while (cyc < a0 + 18) @(negedge clock);
      chk("pre_reset_tx_low", {31'h0, uart_tx}, 32'd0);
      resetn = 1'b0;
      #1;
      chk("midframe_reset_tx", {31'h0, uart_tx}, 32'd1);
      @(negedge clock);
      resetn = 1'b1;
      mon_en = 1'b1;
      rd(BASE + 4, 32'h00000002);
      idle();
      repeat (150) @(negedge clock);
      rd(BASE + 4, 32'h00000002);
      idle();
      repeat (4) @(negedge clock);

      chk("exp_queue_empty", 32'(exp_q.size()), 32'd0);
      chk("rd_queue_empty", 32'(rd_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
